// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: set-mode controller for the watch datapath.
// Picks one field (sec/min/hour), turns held up/down buttons into inc/dec
// pulses with auto-repeat, drives the blink phase and forces idle after
// an inactivity timeout.
// Optional build macro: WATCH_SET_ACCEL_EN (fast auto-repeat after 8 repeats).
module watch_set_ctrl #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter int unsigned BLINK_MS        = 250,
  parameter int unsigned TIMEOUT_MS      = 10_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_set_mode_command,
  input  logic       i_btnL,
  input  logic       i_btnR,
  input  logic       i_btnU,
  input  logic       i_btnD,
  output logic       o_set_sec,
  output logic       o_set_min,
  output logic       o_set_hour,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_blink,
  output logic       o_timeout,
  output logic [2:0] watch_state
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned REP_MAX  = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                                     REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int unsigned REP_W    = $clog2(REP_MAX + 1);
  localparam int unsigned TMO_W    = $clog2(TIMEOUT_MS + 1);
  localparam int unsigned BLK_W    = $clog2(BLINK_MS + 1);
`ifdef WATCH_SET_ACCEL_EN
  localparam int unsigned FAST_MS  = (REPEAT_RATE_MS / 4 > 0) ? REPEAT_RATE_MS / 4 : 1;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    SET_SEC  = 3'b001,
    SET_MIN  = 3'b010,
    SET_HOUR = 3'b100
  } state_t;

  state_t             state, state_n;
  logic [PRE_W-1:0]   presc, presc_n;
  logic [REP_W-1:0]   rep_cnt, rep_n, rep_inc, interval_c;
  logic [TMO_W-1:0]   tmo_cnt, tmo_n;
  logic [BLK_W-1:0]   blink_cnt, blink_cnt_n, blink_inc;
  logic               repeating, repeating_n;
  logic               armed, armed_n;
  logic               lockout, lockout_n;
  logic               blink_n;
  logic               u_prev, d_prev;
  logic               tick_c, in_set_c, stay_set_c, single_c, edge_c;
  logic               entry_c, lr_c, moved_c, pulse_c, timeout_hit_c;
`ifdef WATCH_SET_ACCEL_EN
  logic [3:0]         accel, accel_n;
`endif

  assign watch_state = state;
  assign o_set_sec   = state[0];
  assign o_set_min   = state[1];
  assign o_set_hour  = state[2];

  // Next-state, tick, repeat, timeout and blink decisions
  always_comb begin
    state_n       = state;
    presc_n       = presc + PRE_W'(1);
    rep_n         = rep_cnt;
    rep_inc       = rep_cnt + REP_W'(1);
    repeating_n   = repeating;
    armed_n       = armed;
    tmo_n         = tmo_cnt;
    blink_cnt_n   = blink_cnt;
    blink_inc     = blink_cnt + BLK_W'(1);
    blink_n       = o_blink;
    lockout_n     = lockout;
    pulse_c       = 1'b0;
    timeout_hit_c = 1'b0;
    moved_c       = 1'b0;
`ifdef WATCH_SET_ACCEL_EN
    accel_n       = accel;
    interval_c    = (accel == 4'd8) ? REP_W'(FAST_MS) : REP_W'(REPEAT_RATE_MS);
`else
    interval_c    = REP_W'(REPEAT_RATE_MS);
`endif

    tick_c     = (presc == PRE_W'(TICK_DIV - 1));
    if (tick_c) presc_n = '0;

    in_set_c   = (state != IDLE);
    stay_set_c = in_set_c && i_set_mode_command;
    single_c   = i_btnU ^ i_btnD;
    edge_c     = (i_btnU && !u_prev) || (i_btnD && !d_prev);
    entry_c    = (state == IDLE) && i_set_mode_command && !lockout;
    lr_c       = stay_set_c && (i_btnL || i_btnR);

    // Press edge and auto-repeat; only a fresh single-button edge arms repeat
    if (!stay_set_c || !single_c) begin
      armed_n     = 1'b0;
      rep_n       = '0;
      repeating_n = 1'b0;
`ifdef WATCH_SET_ACCEL_EN
      accel_n     = '0;
`endif
    end else if (edge_c) begin
      armed_n     = 1'b1;
      rep_n       = '0;
      repeating_n = 1'b0;
      pulse_c     = 1'b1;
`ifdef WATCH_SET_ACCEL_EN
      accel_n     = '0;
`endif
    end else if (armed && tick_c) begin
      if ((!repeating && rep_inc == REP_W'(REPEAT_DELAY_MS)) ||
          ( repeating && rep_inc == interval_c)) begin
        pulse_c     = 1'b1;
        rep_n       = '0;
        repeating_n = 1'b1;
`ifdef WATCH_SET_ACCEL_EN
        if (accel != 4'd8) accel_n = accel + 4'd1;
`endif
      end else begin
        rep_n = rep_inc;
      end
    end

    // Inactivity timer; any field move or inc/dec pulse restarts it
    if (!stay_set_c || lr_c || pulse_c) begin
      tmo_n = '0;
    end else if (tick_c) begin
      if (tmo_cnt == TMO_W'(TIMEOUT_MS - 1)) begin
        timeout_hit_c = 1'b1;
        tmo_n         = '0;
      end else begin
        tmo_n = tmo_cnt + TMO_W'(1);
      end
    end

    // Mode FSM: switch-low exit beats timeout beats field moves
    if (in_set_c && !i_set_mode_command) begin
      state_n = IDLE;
    end else if (timeout_hit_c) begin
      state_n = IDLE;
    end else if (entry_c) begin
      state_n = SET_SEC;
    end else if (stay_set_c && (i_btnL ^ i_btnR)) begin
      moved_c = 1'b1;
      case (state)
        SET_SEC:  state_n = i_btnL ? SET_MIN  : SET_HOUR;
        SET_MIN:  state_n = i_btnL ? SET_HOUR : SET_SEC;
        SET_HOUR: state_n = i_btnL ? SET_SEC  : SET_MIN;
        default:  state_n = IDLE;
      endcase
    end

    // Lockout holds idle after a timeout until the switch is lowered
    if (!i_set_mode_command)  lockout_n = 1'b0;
    else if (timeout_hit_c)   lockout_n = 1'b1;

    // Blink phase: visible and restarted on entry, field change or pulse
    if (!stay_set_c || timeout_hit_c || moved_c || pulse_c) begin
      blink_n     = 1'b1;
      blink_cnt_n = '0;
    end else if (tick_c) begin
      if (blink_inc == BLK_W'(BLINK_MS)) begin
        blink_n     = ~o_blink;
        blink_cnt_n = '0;
      end else begin
        blink_cnt_n = blink_inc;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Counters, flags and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      rep_cnt   <= '0;
      tmo_cnt   <= '0;
      blink_cnt <= '0;
      repeating <= 1'b0;
      armed     <= 1'b0;
      lockout   <= 1'b0;
      u_prev    <= 1'b0;
      d_prev    <= 1'b0;
      o_inc     <= 1'b0;
      o_dec     <= 1'b0;
      o_blink   <= 1'b1;
      o_timeout <= 1'b0;
`ifdef WATCH_SET_ACCEL_EN
      accel     <= '0;
`endif
    end else begin
      presc     <= presc_n;
      rep_cnt   <= rep_n;
      tmo_cnt   <= tmo_n;
      blink_cnt <= blink_cnt_n;
      repeating <= repeating_n;
      armed     <= armed_n;
      lockout   <= lockout_n;
      u_prev    <= i_btnU;
      d_prev    <= i_btnD;
      o_inc     <= pulse_c && i_btnU;
      o_dec     <= pulse_c && i_btnD;
      o_blink   <= blink_n;
      o_timeout <= timeout_hit_c;
`ifdef WATCH_SET_ACCEL_EN
      accel     <= accel_n;
`endif
    end
  end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: directed bench for watch_set_ctrl at 4 cycles per ms.
module tb_watch_set_ctrl;

  logic       clk, rst;
  logic       set_mode, btn_l, btn_r, btn_u, btn_d;
  logic       set_sec, set_min, set_hour, inc, dec, blink, tmo;
  logic [2:0] wstate;

  int checks = 0;
  int errors = 0;

  watch_set_ctrl #(
    .CLK_HZ(4000), .REPEAT_DELAY_MS(500), .REPEAT_RATE_MS(100),
    .BLINK_MS(250), .TIMEOUT_MS(2000)
  ) dut (
    .clk(clk), .rst(rst), .i_set_mode_command(set_mode),
    .i_btnL(btn_l), .i_btnR(btn_r), .i_btnU(btn_u), .i_btnD(btn_d),
    .o_set_sec(set_sec), .o_set_min(set_min), .o_set_hour(set_hour),
    .o_inc(inc), .o_dec(dec), .o_blink(blink), .o_timeout(tmo),
    .watch_state(wstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       set, l, r, u, d;
    logic [2:0] st;
    logic       inc, dec, blink, tmo;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(wstate), 0);
    check({tag, "_sel"}, 32'({set_hour, set_min, set_sec}), 0);
    check({tag, "_inc"}, 32'(inc), 0);
    check({tag, "_dec"}, 32'(dec), 0);
    check({tag, "_tmo"}, 32'(tmo), 0);
    check({tag, "_blink"}, 32'(blink), 1);
  endtask

  initial begin
    int first, second, last, cnt, gap_bad, dec_seen, both_seen, t_at, t_cnt, t_state;

    //            set  L    R    U    D    state   inc  dec  blk  tmo
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'b001,1'b0,1'b0,1'b1,1'b0};
    vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'b010,1'b0,1'b0,1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'b100,1'b0,1'b0,1'b1,1'b0};
    vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'b001,1'b0,1'b0,1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,3'b100,1'b0,1'b0,1'b1,1'b0};
    vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,3'b100,1'b0,1'b0,1'b1,1'b0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'b100,1'b0,1'b0,1'b1,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,3'b010,1'b0,1'b0,1'b1,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,3'b001,1'b0,1'b0,1'b1,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,1'b0};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,1'b0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'b001,1'b0,1'b0,1'b1,1'b0};
    vecs[13] = '{1'b1,1'b0,1'b0,1'b1,1'b0,3'b001,1'b1,1'b0,1'b1,1'b0};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b1,1'b0,3'b001,1'b0,1'b0,1'b1,1'b0};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b0,1'b1,3'b001,1'b0,1'b1,1'b1,1'b0};
    vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'b001,1'b0,1'b0,1'b1,1'b0};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,1'b1,1'b0};

    rst = 1'b1; set_mode = 1'b0; btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
    repeat (3) sample();
    check_reset_vals("reset");
    @(negedge clk) rst = 1'b0;

    // Table: field navigation, IDLE gating, press-edge pulses
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      set_mode = vecs[i].set; btn_l = vecs[i].l; btn_r = vecs[i].r;
      btn_u = vecs[i].u; btn_d = vecs[i].d;
      sample();
      check($sformatf("vec%0d_state", i), 32'(wstate), 32'(vecs[i].st));
      check($sformatf("vec%0d_sel", i), 32'({set_hour, set_min, set_sec}), 32'(vecs[i].st));
      check($sformatf("vec%0d_inc", i), 32'(inc), 32'(vecs[i].inc));
      check($sformatf("vec%0d_dec", i), 32'(dec), 32'(vecs[i].dec));
      check($sformatf("vec%0d_blink", i), 32'(blink), 32'(vecs[i].blink));
      check($sformatf("vec%0d_tmo", i), 32'(tmo), 32'(vecs[i].tmo));
    end

    // Blink: 250 ticks after entry (996..1000 cycles depending on tick phase)
    @(negedge clk) set_mode = 1'b1;
    sample();
    check("blink_entry_state", 32'(wstate), 1);
    for (int k = 1; k <= 1001; k++) begin
      sample();
      if (k == 996)  check("blink_before_toggle", 32'(blink), 1);
      if (k == 1001) check("blink_after_toggle", 32'(blink), 0);
    end
    @(negedge clk) btn_l = 1'b1;
    sample();
    check("blink_field_change", 32'(blink), 1);
    check("blink_field_state", 32'(wstate), 2);
    @(negedge clk) btn_l = 1'b0;

    // Hold U for 1200 ms: edge pulse, then ~500 ms, then every 100 ms
    @(negedge clk) btn_u = 1'b1;
    first = -1; second = -1; last = -1; cnt = 0; gap_bad = 0; dec_seen = 0; both_seen = 0;
    for (int k = 1; k <= 4800; k++) begin
      sample();
      if (dec) dec_seen++;
      if (inc && dec) both_seen++;
      if (inc) begin
        cnt++;
        if (cnt == 1) first = k;
        else if (cnt == 2) second = k;
        else if (k - last != 400) gap_bad++;
        last = k;
      end
    end
    check("hold_first_latency", 32'(first), 1);
    check("hold_delay_gap_ok", 32'((second - first >= 1996) && (second - first <= 2004)), 1);
    check("hold_rate_gap_errors", 32'(gap_bad), 0);
    check("hold_pulse_count_ok", 32'((cnt >= 8) && (cnt <= 9)), 1);
    check("hold_dec_seen", 32'(dec_seen), 0);
    check("hold_inc_dec_overlap", 32'(both_seen), 0);
    @(negedge clk) btn_u = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (inc) cnt++;
    end
    check("release_no_pulse", 32'(cnt), 0);

    // U and D together, then D released: never a pulse
    @(negedge clk) btn_l = 1'b1;
    @(negedge clk) begin btn_l = 1'b0; btn_u = 1'b1; btn_d = 1'b1; end
    cnt = 0;
    for (int k = 0; k < 4000; k++) begin
      sample();
      if (inc || dec) cnt++;
    end
    check("both_held_pulses", 32'(cnt), 0);
    @(negedge clk) btn_d = 1'b0;
    cnt = 0;
    for (int k = 0; k < 2400; k++) begin
      sample();
      if (inc || dec) cnt++;
    end
    check("after_d_release_pulses", 32'(cnt), 0);
    check("both_state", 32'(wstate), 4);
    @(negedge clk) btn_u = 1'b0;

    // Timeout after 2000 idle ticks from the last L press
    @(negedge clk) btn_l = 1'b1;
    sample();
    check("tmo_pre_state", 32'(wstate), 1);
    @(negedge clk) btn_l = 1'b0;
    t_at = -1; t_cnt = 0; t_state = -1;
    for (int k = 2; k <= 8100; k++) begin
      sample();
      if (tmo) begin
        t_cnt++;
        if (t_at < 0) begin t_at = k; t_state = int'(wstate); end
      end
    end
    check("tmo_time_ok", 32'((t_at >= 7996) && (t_at <= 8004)), 1);
    check("tmo_pulse_count", 32'(t_cnt), 1);
    check("tmo_state", 32'(t_state), 0);
    check("tmo_locked_idle", 32'(wstate), 0);
    @(negedge clk) set_mode = 1'b0;
    sample();
    @(negedge clk) set_mode = 1'b1;
    sample();
    check("tmo_reentry_state", 32'(wstate), 1);

    // Reset while repeating, then re-entry with U still held
    @(negedge clk) btn_u = 1'b1;
    repeat (2100) sample();
    @(negedge clk) rst = 1'b1;
    sample();
    check_reset_vals("midrst");
    @(negedge clk) rst = 1'b0;
    sample();
    check("midrst_entry_state", 32'(wstate), 1);
    cnt = 0;
    for (int k = 0; k < 2500; k++) begin
      sample();
      if (inc || dec) cnt++;
    end
    check("held_reentry_pulses", 32'(cnt), 0);
    @(negedge clk) set_mode = 1'b0;
    sample();
    check("exit_hold_state", 32'(wstate), 0);
    check("exit_hold_inc", 32'(inc), 0);
    @(negedge clk) btn_u = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
